// File: rtl/rs_pkg.sv
// Shared types for the reservation station.
// Contents: entry state enum, tag type, entry record, overwrite field positions.
package rs_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } rs_state_e;

  typedef logic [2:0] tag_t;

  typedef struct packed {
    rs_state_e   state;
    logic        src1_rdy;
    tag_t        src1_tag;
    logic [31:0] src1_val;
    logic        src2_rdy;
    tag_t        src2_tag;
    logic [31:0] src2_val;
    logic [1:0]  age;
  } rs_entry_t;

  // Overwrite command layout: {is_rs2, idx[1:0], tag[2:0]}
  localparam int unsigned OVR_IS_RS2 = 5;
  localparam int unsigned OVR_IDX_HI = 4;
  localparam int unsigned OVR_IDX_LO = 3;
  localparam int unsigned OVR_TAG_HI = 2;
  localparam int unsigned OVR_TAG_LO = 0;

endpackage

// File: rtl/rs_select.sv
// Issue selector: picks one entry from the READY mask.
// Ports: ready_i (READY mask), age_i (per-entry age rank, RS_OLDEST_FIRST_EN only),
//        valid_o (some entry selected), grant_o (one-hot), idx_o (selected index).
// Macro RS_OLDEST_FIRST_EN: oldest (lowest rank) READY entry wins; otherwise lowest index.
module rs_select
  import rs_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      ready_i,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [N-1:0][1:0] age_i,
`endif
  output logic              valid_o,
  output logic [N-1:0]      grant_o,
  output logic [1:0]        idx_o
);

  always_comb begin
`ifdef RS_OLDEST_FIRST_EN
    logic [1:0] best;
    best = '1;
`endif
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef RS_OLDEST_FIRST_EN
      if (ready_i[i] && (!valid_o || age_i[i] < best)) begin
        best    = age_i[i];
`else
      if (ready_i[i] && !valid_o) begin
`endif
        valid_o = 1'b1;
        idx_o   = i[1:0];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      grant_o[i] = valid_o && (idx_o == i[1:0]);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Four-entry reservation station for one functional unit.
// Inputs: two allocation ports, RAW overwrite command, CDB broadcast, flush, issue_ready.
// Outputs: busy bitmap, count_free, issue_valid/issue_tag/issue_op1/issue_op2.
// An entry index is its result tag ({FU_ID, idx}); the entry stays ISSUED until that
// tag is broadcast. err_alloc_q is a sticky flag for dropped allocations.
// Macro RS_OLDEST_FIRST_EN: per-entry age rank, oldest READY entry issues first.
module reservation_station
  import rs_pkg::*;
#(
  parameter logic        FU_ID       = 1'b0,
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc0_valid,
  input  logic [1:0]             alloc0_idx,
  input  logic                   alloc0_src1_rdy,
  input  logic                   alloc0_src2_rdy,
  input  logic [2:0]             alloc0_src1_tag,
  input  logic [2:0]             alloc0_src2_tag,
  input  logic [31:0]            alloc0_src1_val,
  input  logic [31:0]            alloc0_src2_val,
  input  logic                   alloc1_valid,
  input  logic [1:0]             alloc1_idx,
  input  logic                   alloc1_src1_rdy,
  input  logic                   alloc1_src2_rdy,
  input  logic [2:0]             alloc1_src1_tag,
  input  logic [2:0]             alloc1_src2_tag,
  input  logic [31:0]            alloc1_src1_val,
  input  logic [31:0]            alloc1_src2_val,
  input  logic                   ovr_valid,
  input  logic [5:0]             ovr,
  input  logic                   cdb_valid,
  input  logic [2:0]             cdb_tag,
  input  logic [31:0]            cdb_data,
  output logic [NUM_ENTRIES-1:0] busy,
  output logic [2:0]             count_free,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [2:0]             issue_tag,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2
);

  rs_entry_t              ent_q [NUM_ENTRIES];
  rs_entry_t              ent_d [NUM_ENTRIES];
  logic                   err_alloc_q, err_alloc_d;
  logic [NUM_ENTRIES-1:0] ready_mask, freeing, sel_grant;
  logic                   sel_valid;
  logic [1:0]             sel_idx;
  logic                   issue_fire, alloc_same, alloc0_ok, alloc1_ok;
  logic [1:0]             age_next [NUM_ENTRIES];
  logic [1:0]             age_new0, age_new1;
  logic                   ovr_rs2;
  logic [1:0]             ovr_idx;
  tag_t                   ovr_tag;

  assign ovr_rs2 = ovr[OVR_IS_RS2];
  assign ovr_idx = ovr[OVR_IDX_HI:OVR_IDX_LO];
  assign ovr_tag = ovr[OVR_TAG_HI:OVR_TAG_LO];

  // Capture CDB data into any pending source whose tag matches.
  function automatic rs_entry_t capture(input rs_entry_t e, input logic v, input tag_t t,
                                        input logic [31:0] d);
    rs_entry_t r;
    r = e;
    if (v && !r.src1_rdy && r.src1_tag == t) begin
      r.src1_rdy = 1'b1;
      r.src1_val = d;
    end
    if (v && !r.src2_rdy && r.src2_tag == t) begin
      r.src2_rdy = 1'b1;
      r.src2_val = d;
    end
    return r;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ready_mask[i] = (ent_q[i].state == READY);
      busy[i]       = (ent_q[i].state != FREE);
      freeing[i]    = (ent_q[i].state == ISSUED) && cdb_valid && (cdb_tag == {FU_ID, i[1:0]});
    end
  end

  always_comb begin
    count_free = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      count_free = count_free + {2'b00, ~busy[i]};
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [NUM_ENTRIES-1:0][1:0] age_q_vec;

  // Ranks are dense (0 = oldest): survivors shift down past freed older entries,
  // new entries take the next ranks after all survivors, alloc0 before alloc1.
  // surv may wrap when all four survive, but then nothing can be allocated.
  always_comb begin
    logic [1:0] surv;
    logic [1:0] shift;
    surv = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      age_q_vec[i] = ent_q[i].age;
      if (ent_q[i].state != FREE && !freeing[i]) surv = surv + 2'd1;
    end
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      shift = '0;
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
        if (freeing[j] && ent_q[j].age < ent_q[i].age) shift = shift + 2'd1;
      end
      age_next[i] = ent_q[i].age - shift;
    end
    age_new0 = surv;
    age_new1 = surv + {1'b0, alloc0_ok};
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) age_next[i] = '0;
    age_new0 = '0;
    age_new1 = '0;
  end
`endif

  rs_select #(.N(NUM_ENTRIES)) u_select (
    .ready_i (ready_mask),
`ifdef RS_OLDEST_FIRST_EN
    .age_i   (age_q_vec),
`endif
    .valid_o (sel_valid),
    .grant_o (sel_grant),
    .idx_o   (sel_idx)
  );

  // Per-entry update order: wakeup, issue, free, allocate (+bypass), overwrite,
  // then WAIT/READY re-derived from the source ready bits. Allocation legality is
  // judged on the registered state, so an entry freed this edge is not reusable yet.
  always_comb begin
    rs_entry_t e;
    issue_fire  = sel_valid && issue_ready;
    alloc_same  = alloc0_valid && alloc1_valid && (alloc0_idx == alloc1_idx);
    alloc0_ok   = alloc0_valid && (ent_q[alloc0_idx].state == FREE);
    alloc1_ok   = alloc1_valid && !alloc_same && (ent_q[alloc1_idx].state == FREE);
    err_alloc_d = flush ? 1'b0
                        : (err_alloc_q || (alloc0_valid && !alloc0_ok) || (alloc1_valid && !alloc1_ok));
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      e = ent_q[i];
      if (e.state == WAIT) e = capture(e, cdb_valid, cdb_tag, cdb_data);
      if (issue_fire && sel_grant[i]) e.state = ISSUED;
      if (freeing[i]) e.state = FREE;
      e.age = age_next[i];
      if (alloc0_ok && alloc0_idx == i[1:0]) begin
        e.state    = WAIT;
        e.src1_rdy = alloc0_src1_rdy;
        e.src1_tag = alloc0_src1_tag;
        e.src1_val = alloc0_src1_val;
        e.src2_rdy = alloc0_src2_rdy;
        e.src2_tag = alloc0_src2_tag;
        e.src2_val = alloc0_src2_val;
        e.age      = age_new0;
        e = capture(e, cdb_valid, cdb_tag, cdb_data);
      end else if (alloc1_ok && alloc1_idx == i[1:0]) begin
        e.state    = WAIT;
        e.src1_rdy = alloc1_src1_rdy;
        e.src1_tag = alloc1_src1_tag;
        e.src1_val = alloc1_src1_val;
        e.src2_rdy = alloc1_src2_rdy;
        e.src2_tag = alloc1_src2_tag;
        e.src2_val = alloc1_src2_val;
        e.age      = age_new1;
        e = capture(e, cdb_valid, cdb_tag, cdb_data);
      end
      if (ovr_valid && ovr_idx == i[1:0] && (e.state == WAIT || e.state == READY)) begin
        if (ovr_rs2) begin
          e.src2_tag = ovr_tag;
          e.src2_rdy = cdb_valid && (cdb_tag == ovr_tag);
          if (e.src2_rdy) e.src2_val = cdb_data;
        end else begin
          e.src1_tag = ovr_tag;
          e.src1_rdy = cdb_valid && (cdb_tag == ovr_tag);
          if (e.src1_rdy) e.src1_val = cdb_data;
        end
      end
      if (e.state == WAIT || e.state == READY) e.state = (e.src1_rdy && e.src2_rdy) ? READY : WAIT;
      ent_d[i] = flush ? '0 : e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
      err_alloc_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
      err_alloc_q <= err_alloc_d;
    end
  end

  always_comb begin
    issue_valid = sel_valid;
    issue_tag   = '0;
    issue_op1   = '0;
    issue_op2   = '0;
    if (sel_valid) begin
      issue_tag = {FU_ID, sel_idx};
      issue_op1 = ent_q[sel_idx].src1_val;
      issue_op2 = ent_q[sel_idx].src2_val;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  localparam logic FU = 1'b0;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alloc0_valid, alloc1_valid;
  logic [1:0]  alloc0_idx, alloc1_idx;
  logic        alloc0_src1_rdy, alloc0_src2_rdy, alloc1_src1_rdy, alloc1_src2_rdy;
  logic [2:0]  alloc0_src1_tag, alloc0_src2_tag, alloc1_src1_tag, alloc1_src2_tag;
  logic [31:0] alloc0_src1_val, alloc0_src2_val, alloc1_src1_val, alloc1_src2_val;
  logic        ovr_valid;
  logic [5:0]  ovr;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  busy;
  logic [2:0]  count_free;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_tag;
  logic [31:0] issue_op1, issue_op2;

  reservation_station #(.FU_ID(FU), .NUM_ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc0_valid(alloc0_valid), .alloc0_idx(alloc0_idx),
    .alloc0_src1_rdy(alloc0_src1_rdy), .alloc0_src2_rdy(alloc0_src2_rdy),
    .alloc0_src1_tag(alloc0_src1_tag), .alloc0_src2_tag(alloc0_src2_tag),
    .alloc0_src1_val(alloc0_src1_val), .alloc0_src2_val(alloc0_src2_val),
    .alloc1_valid(alloc1_valid), .alloc1_idx(alloc1_idx),
    .alloc1_src1_rdy(alloc1_src1_rdy), .alloc1_src2_rdy(alloc1_src2_rdy),
    .alloc1_src1_tag(alloc1_src1_tag), .alloc1_src2_tag(alloc1_src2_tag),
    .alloc1_src1_val(alloc1_src1_val), .alloc1_src2_val(alloc1_src2_val),
    .ovr_valid(ovr_valid), .ovr(ovr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .busy(busy), .count_free(count_free),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_op1(issue_op1), .issue_op2(issue_op2)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: occupancy/issued flags, operand slots, allocation order queue.
  bit          m_occ [4];
  bit          m_iss [4];
  bit          m_r1  [4];
  bit          m_r2  [4];
  logic [2:0]  m_t1  [4];
  logic [2:0]  m_t2  [4];
  logic [31:0] m_v1  [4];
  logic [31:0] m_v2  [4];
  bit          m_err;
  int          m_order[$];

  function automatic bit m_ready(input int k);
    return m_occ[k] && !m_iss[k] && m_r1[k] && m_r2[k];
  endfunction

  function automatic int m_pick();
`ifdef RS_OLDEST_FIRST_EN
    for (int k = 0; k < m_order.size(); k++) if (m_ready(m_order[k])) return m_order[k];
`else
    for (int k = 0; k < 4; k++) if (m_ready(k)) return k;
`endif
    return -1;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 4; k++) begin
      m_occ[k] = 0; m_iss[k] = 0; m_r1[k] = 0; m_r2[k] = 0;
    end
    m_err = 0;
    m_order.delete();
  endtask

  task automatic m_src(input logic r, input logic [2:0] t, input logic [31:0] v,
                       output bit ro, output logic [2:0] to, output logic [31:0] vo);
    to = t;
    if (r) begin ro = 1; vo = v; end
    else if (cdb_valid && cdb_tag == t) begin ro = 1; vo = cdb_data; end
    else begin ro = 0; vo = v; end
  endtask

  task automatic m_load(input int k, input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    m_occ[k] = 1;
    m_iss[k] = 0;
    m_src(r1, t1, v1, m_r1[k], m_t1[k], m_v1[k]);
    m_src(r2, t2, v2, m_r2[k], m_t2[k], m_v2[k]);
    m_order.push_back(k);
  endtask

  // Applies one clock edge of the spec's rules to the model, using current inputs.
  task automatic m_edge();
    int sel;
    bit occ_now [4];
    int k;
    if (flush) begin
      m_clear();
      return;
    end
    sel = m_pick();
    for (int i = 0; i < 4; i++) occ_now[i] = m_occ[i];
    if (cdb_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (m_occ[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_data; end
        if (m_occ[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_data; end
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ii;
      ii = 2'(i);
      if (m_iss[i] && cdb_valid && cdb_tag == {FU, ii}) begin
        m_occ[i] = 0;
        m_iss[i] = 0;
        for (int q = m_order.size() - 1; q >= 0; q--) if (m_order[q] == i) m_order.delete(q);
      end
    end
    if (sel >= 0 && issue_ready) m_iss[sel] = 1;
    if (alloc0_valid) begin
      if (occ_now[alloc0_idx]) m_err = 1;
      else m_load(int'(alloc0_idx), alloc0_src1_rdy, alloc0_src1_tag, alloc0_src1_val,
                  alloc0_src2_rdy, alloc0_src2_tag, alloc0_src2_val);
    end
    if (alloc1_valid) begin
      if ((alloc0_valid && alloc0_idx == alloc1_idx) || occ_now[alloc1_idx]) m_err = 1;
      else m_load(int'(alloc1_idx), alloc1_src1_rdy, alloc1_src1_tag, alloc1_src1_val,
                  alloc1_src2_rdy, alloc1_src2_tag, alloc1_src2_val);
    end
    if (ovr_valid) begin
      k = int'(ovr[4:3]);
      if (m_occ[k] && !m_iss[k]) begin
        if (ovr[5]) m_src(1'b0, ovr[2:0], m_v2[k], m_r2[k], m_t2[k], m_v2[k]);
        else        m_src(1'b0, ovr[2:0], m_v1[k], m_r1[k], m_t1[k], m_v1[k]);
      end
    end
  endtask

  task automatic check_outputs();
    int sel;
    int nocc;
    logic [3:0] eb;
    logic [1:0] s2;
    sel = m_pick();
    nocc = 0;
    for (int i = 0; i < 4; i++) begin
      eb[i] = m_occ[i];
      if (m_occ[i]) nocc++;
    end
    check("busy", 32'(busy), 32'(eb));
    check("count_free", 32'(count_free), 32'(4 - nocc));
    check("err_alloc", 32'(dut.err_alloc_q), 32'(m_err));
    check("issue_valid", 32'(issue_valid), 32'(sel >= 0));
    if (sel >= 0) begin
      s2 = 2'(sel);
      check("issue_tag", 32'(issue_tag), 32'({FU, s2}));
      check("issue_op1", issue_op1, m_v1[sel]);
      check("issue_op2", issue_op2, m_v2[sel]);
    end else begin
      check("issue_tag_idle", 32'(issue_tag), 32'd0);
      check("issue_ops_idle", issue_op1 | issue_op2, 32'd0);
    end
  endtask

  task automatic idle();
    flush = 0; alloc0_valid = 0; alloc1_valid = 0; ovr_valid = 0; ovr = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; issue_ready = 0;
    alloc0_idx = '0; alloc0_src1_rdy = 0; alloc0_src2_rdy = 0; alloc0_src1_tag = '0;
    alloc0_src2_tag = '0; alloc0_src1_val = '0; alloc0_src2_val = '0;
    alloc1_idx = '0; alloc1_src1_rdy = 0; alloc1_src2_rdy = 0; alloc1_src1_tag = '0;
    alloc1_src2_tag = '0; alloc1_src1_val = '0; alloc1_src2_val = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    m_edge();
    check_outputs();
    idle();
  endtask

  task automatic a0(input logic [1:0] idx, input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                    input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    alloc0_valid = 1; alloc0_idx = idx;
    alloc0_src1_rdy = r1; alloc0_src1_tag = t1; alloc0_src1_val = v1;
    alloc0_src2_rdy = r2; alloc0_src2_tag = t2; alloc0_src2_val = v2;
  endtask

  task automatic a1(input logic [1:0] idx, input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                    input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    alloc1_valid = 1; alloc1_idx = idx;
    alloc1_src1_rdy = r1; alloc1_src1_tag = t1; alloc1_src1_val = v1;
    alloc1_src2_rdy = r2; alloc1_src2_tag = t2; alloc1_src2_val = v2;
  endtask

  task automatic bcast(input logic [2:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  function automatic logic [1:0] pick_idx();
    int fl[$];
    for (int i = 0; i < 4; i++) if (!m_occ[i]) fl.push_back(i);
    if (fl.size() > 0 && $urandom_range(99) < 85) return 2'(fl[$urandom_range(fl.size() - 1)]);
    return 2'($urandom_range(3));
  endfunction

  initial begin
    int issued_list[$];
    idle();
    m_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_outputs();

    // Both sources ready: issuable next cycle, then retire on own tag.
    a0(2'd0, 1, 3'd0, 32'd5, 1, 3'd0, 32'd7); issue_ready = 1; cycle();
    check("t1_valid", 32'(issue_valid), 32'd1);
    check("t1_tag", 32'(issue_tag), 32'({FU, 2'b00}));
    check("t1_op1", issue_op1, 32'd5);
    check("t1_op2", issue_op2, 32'd7);
    issue_ready = 1; cycle();
    bcast({FU, 2'b00}, 32'hDEAD); cycle();
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_free", 32'(count_free), 32'd4);

    // src2 waits on tag 100, woken by CDB.
    a0(2'd1, 1, 3'd0, 32'd3, 0, 3'b100, 32'd0); cycle();
    check("t2_wait", 32'(issue_valid), 32'd0);
    bcast(3'b100, 32'h2A); cycle();
    check("t2_valid", 32'(issue_valid), 32'd1);
    check("t2_tag", 32'(issue_tag), 32'({FU, 2'b01}));
    check("t2_op2", issue_op2, 32'h2A);
    issue_ready = 1; cycle();
    bcast({FU, 2'b01}, 32'd0); cycle();

    // Both ports to the same index: alloc0 wins, error flagged.
    a0(2'd2, 1, 3'd0, 32'h11, 1, 3'd0, 32'h22);
    a1(2'd2, 1, 3'd0, 32'h33, 1, 3'd0, 32'h44); cycle();
    check("t3_err", 32'(dut.err_alloc_q), 32'd1);
    check("t3_free", 32'(count_free), 32'd3);
    check("t3_op1", issue_op1, 32'h11);
    issue_ready = 1; cycle();
    bcast({FU, 2'b10}, 32'd0); cycle();

    // Same-cycle overwrite after allocation, then CDB capture.
    a0(2'd0, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2); ovr_valid = 1; ovr = 6'b1_00_101; cycle();
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_wait", 32'(issue_valid), 32'd0);
    bcast(3'b101, 32'd9); cycle();
    check("t4_op2", issue_op2, 32'd9);
    issue_ready = 1; cycle();
    bcast({FU, 2'b00}, 32'd0); cycle();

    // Fill, then flush with a concurrent allocation and CDB.
    a0(2'd0, 0, 3'b111, 32'd0, 1, 3'd0, 32'd1); a1(2'd1, 0, 3'b111, 32'd0, 1, 3'd0, 32'd2); cycle();
    a0(2'd2, 0, 3'b111, 32'd0, 1, 3'd0, 32'd3); a1(2'd3, 0, 3'b111, 32'd0, 1, 3'd0, 32'd4); cycle();
    check("t5_full", 32'(count_free), 32'd0);
    flush = 1; a0(2'd0, 1, 3'd0, 32'd8, 1, 3'd0, 32'd8); bcast(3'b111, 32'd1); cycle();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_free", 32'(count_free), 32'd4);
    check("t5_valid", 32'(issue_valid), 32'd0);
    check("t5_err", 32'(dut.err_alloc_q), 32'd0);

    // Select policy: idx 3 allocated before idx 0.
    a0(2'd3, 1, 3'd0, 32'd30, 1, 3'd0, 32'd31); cycle();
    a0(2'd0, 1, 3'd0, 32'd40, 1, 3'd0, 32'd41); cycle();
`ifdef RS_OLDEST_FIRST_EN
    check("t6_tag", 32'(issue_tag), 32'({FU, 2'b11}));
`else
    check("t6_tag", 32'(issue_tag), 32'({FU, 2'b00}));
`endif
    flush = 1; cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(63) == 0);
      if ($urandom_range(1) == 1)
        a0(pick_idx(), 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
           1'($urandom_range(1)), 3'($urandom_range(7)), $urandom);
      if ($urandom_range(2) == 0)
        a1(pick_idx(), 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
           1'($urandom_range(1)), 3'($urandom_range(7)), $urandom);
      if ($urandom_range(9) == 0) begin
        ovr_valid = 1;
        ovr = 6'($urandom_range(63));
      end
      if ($urandom_range(1) == 1) begin
        issued_list.delete();
        for (int i = 0; i < 4; i++) if (m_iss[i]) issued_list.push_back(i);
        if (issued_list.size() > 0 && $urandom_range(1) == 1)
          bcast({FU, 2'(issued_list[$urandom_range(issued_list.size() - 1)])}, $urandom);
        else
          bcast(3'($urandom_range(7)), $urandom);
      end
      issue_ready = ($urandom_range(3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Four-entry reservation station sitting downstream of the two dispatch units; one instance serves the adder FU and one the multiplier FU. It accepts up to two allocations per cycle, applies dispatch RAW-overwrite commands, captures operands from the common data bus (CDB), and issues ready entries to its functional unit. It reports occupancy back to dispatch as a busy bitmap and free count. An entry's index is its tag, so an entry is held until its own result is broadcast.

## Interface
- FU_ID, 0: tag MSB for this station (0 adder, 1 multiplier)
- NUM_ENTRIES, 4: entry count; fixed at 4 (2-bit index)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all entries
- alloc0_valid / alloc1_valid  in  1  allocation request, dispatch 1 / dispatch 2
- allocN_idx  in  2  target entry
- allocN_src1_rdy, allocN_src2_rdy  in  1  operand already valid
- allocN_src1_tag, allocN_src2_tag  in  3  producer tag when not ready
- allocN_src1_val, allocN_src2_val  in  32  operand value when ready
- ovr_valid  in  1  overwrite command strobe
- ovr  in  6  {is_rs2, idx[1:0], tag[2:0]}: mark source of entry idx as waiting on tag
- cdb_valid  in  1  result broadcast
- cdb_tag  in  3  producer tag
- cdb_data  in  32  result value
- busy  out  4  per-entry occupied flag
- count_free  out  3  number of free entries, 0..4
- issue_valid  out  1  an entry is ready to execute
- issue_ready  in  1  FU accepts
- issue_tag  out  3  {FU_ID, idx}
- issue_op1, issue_op2  out  32  operands

## Operation
- Entry states: FREE -> WAIT (a source is pending) or READY (both sources valid) on allocation; WAIT -> READY when the last pending source is captured; READY -> ISSUED on issue handshake; ISSUED -> FREE when cdb_valid and cdb_tag == {FU_ID, idx}.
- Wakeup: every WAIT source whose tag matches cdb_tag captures cdb_data and sets rdy.
- Allocation bypass: an allocating source whose tag matches the same-cycle CDB captures cdb_data directly.
- Overwrite: clears rdy of the selected source and loads the tag. It applies after a same-cycle allocation to that entry. It is ignored if the entry is FREE or ISSUED. If its tag matches the same-cycle CDB, the data is captured instead.
- Allocation to a non-FREE entry is dropped and pulses sticky err_alloc (internal, visible to the bench).
- If both allocation ports target the same idx, alloc0 wins and err_alloc is set.
- Issue select: the lowest-index READY entry. Outputs are combinational from entry registers.
- busy[i] = (state != FREE). count_free = popcount(~busy).

## Timing
- Reset / flush: all entries FREE, busy = 0, count_free = 4, issue_valid = 0, issue_tag/ops = 0, err_alloc = 0. Flush is synchronous and overrides every same-cycle alloc, ovr, CDB and issue event.
- Allocation with both sources ready at edge N: busy set and issue_valid high in cycle N+1.
- CDB wakeup at edge N: the entry is READY and issuable in cycle N+1.
- Handshake at edge N: the entry is ISSUED in N+1, and the next READY entry is presented in N+1.
- An entry freed at edge N is counted in count_free in N+1 and may be reallocated at edge N+1.
- Full station (count_free = 0): dispatch must not allocate; violations set err_alloc.

## Configuration
- RS_OLDEST_FIRST_EN:
  - Defined: each entry carries a 2-bit age rank, assigned at allocation and compacted on free. Issue selects the oldest READY entry. When both ports allocate in the same cycle, alloc0 is older.
  - Undefined: lowest-index select and no age state.

## Structure
- Package rs_pkg:
  - rs_state_e (FREE, WAIT, READY, ISSUED)
  - tag_t (3 bits)
  - rs_entry_t (state, src rdy/tag/val x2, age)
  - OVR_IS_RS2 / OVR_IDX / OVR_TAG field positions
- Sub-module rs_select: picks the issue entry from the READY mask (and ages when enabled) and outputs the one-hot grant and index.

## Test plan
- Allocate idx 0 with ops 5 and 7, both ready, issue_ready = 1 -> issue_valid in the next cycle, issue_tag = {FU_ID,00}, op1 = 5, op2 = 7. Then CDB tag {FU_ID,00} -> busy = 0, count_free = 4.
- Allocate idx 1 with src2 waiting on tag 3'b100. CDB tag 100, data 0x2A -> op2 = 0x2A and issued in the following cycle.
- Same-cycle alloc0 and alloc1 to idx 2 -> only the alloc0 payload is stored, err_alloc = 1, count_free = 3.
- Alloc idx 0 with sources ready plus same-cycle ovr = {1,00,101} -> entry in WAIT. CDB tag 101, data 9 -> op2 = 9.
- Fill all 4 entries, then assert flush mid-wait together with an alloc -> next cycle busy = 0, count_free = 4, issue_valid = 0.
- With RS_OLDEST_FIRST_EN: allocate idx 3, then idx 0, both ready -> idx 3 issues first. Without the macro -> idx 0 issues first.
